// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding and default widths.
package psum_acc_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_ACC_WIDTH   = 32;
  localparam int unsigned DEF_CNT_WIDTH   = 8;
  localparam int unsigned DEF_SHIFT_WIDTH = 5;

  // Column psum width from the MAC array: product of two operands plus growth bits.
  function automatic int unsigned col_out_width(input int unsigned data_width);
    return 2 * data_width + 3;
  endfunction

  localparam int unsigned DEF_COLUMN_OUT_WIDTH = col_out_width(DEF_DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Psum input stream and activation output stream of the accumulator.
interface psum_accumulator_if
  import psum_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned COLUMN_OUT_WIDTH = DEF_COLUMN_OUT_WIDTH
);

  logic                               i_psum_valid;
  logic signed [COLUMN_OUT_WIDTH-1:0] i_psum_column;
  logic                               o_psum_ready;
  logic                               o_out_valid;
  logic signed [DATA_WIDTH-1:0]       o_out_data;
  logic                               i_out_ready;

  // Upstream psum producer and downstream activation consumer side.
  modport master (
    output i_psum_valid,
    output i_psum_column,
    input  o_psum_ready,
    input  o_out_valid,
    input  o_out_data,
    output i_out_ready
  );

  // Accumulator side.
  modport slave (
    input  i_psum_valid,
    input  i_psum_column,
    output o_psum_ready,
    output o_out_valid,
    output o_out_data,
    input  i_out_ready
  );

endinterface

// File: rtl/psum_quantizer.sv
// Requantizes a wide signed accumulator value: round-half-up shift, optional ReLU, saturate.
module psum_quantizer
  import psum_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  sum_i,
  input  logic [SHIFT_WIDTH-1:0]       shift_i,
  input  logic                         relu_en_i,
  output logic signed [DATA_WIDTH-1:0] data_c_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned EXT_W = ACC_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] rnd_bias;
  logic signed [EXT_W-1:0] shifted;

  // Round, shift, rectify and clamp to the activation range.
  always_comb begin
    sum_ext  = {sum_i[ACC_WIDTH-1], sum_i};
    rnd_bias = '0;
    if (shift_i != '0) begin
      rnd_bias = EXT_W'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    shifted = (sum_ext + rnd_bias) >>> shift_i;
    if (relu_en_i && shifted[EXT_W-1]) begin
      shifted = '0;
    end
    if (shifted > SAT_MAX) begin
      data_c_o = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      data_c_o = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      data_c_o = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates column partial sums onto a bias and emits one quantized activation per group.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned COLUMN_OUT_WIDTH = col_out_width(DATA_WIDTH),
  parameter int unsigned ACC_WIDTH        = DEF_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH        = DEF_CNT_WIDTH,
  parameter int unsigned SHIFT_WIDTH      = DEF_SHIFT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [CNT_WIDTH-1:0]   i_acc_len,
  input  logic [CNT_WIDTH-1:0]   i_num_out,
  input  logic [ACC_WIDTH-1:0]   i_bias,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic                   i_relu_en,
  psum_accumulator_if.slave      bus,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned EXT_BITS = ACC_WIDTH - COLUMN_OUT_WIDTH;

  state_t                       state_q,      state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q,        acc_d;
  logic [CNT_WIDTH-1:0]         psum_cnt_q,   psum_cnt_d;
  logic [CNT_WIDTH-1:0]         out_cnt_q,    out_cnt_d;
  logic [CNT_WIDTH-1:0]         acc_len_q,    acc_len_d;
  logic [CNT_WIDTH-1:0]         num_out_q,    num_out_d;
  logic signed [ACC_WIDTH-1:0]  bias_q,       bias_d;
  logic [SHIFT_WIDTH-1:0]       shift_q,      shift_d;
  logic                         relu_en_q,    relu_en_d;
  logic signed [DATA_WIDTH-1:0] out_data_q,   out_data_d;
  logic                         psum_ready_q, psum_ready_d;
  logic                         out_valid_q,  out_valid_d;
  logic                         busy_q,       busy_d;
  logic                         done_q,       done_d;

  logic                         psum_hs_c;
  logic                         out_hs_c;
  logic signed [ACC_WIDTH-1:0]  acc_sum_c;
  logic signed [DATA_WIDTH-1:0] quant_c;

  assign psum_hs_c = bus.i_psum_valid && psum_ready_q;
  assign out_hs_c  = out_valid_q && bus.i_out_ready;
  assign acc_sum_c = acc_q + {{EXT_BITS{bus.i_psum_column[COLUMN_OUT_WIDTH-1]}},
                              bus.i_psum_column};

  // Quantize the running sum including the psum currently being accepted.
  psum_quantizer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_quantizer (
    .sum_i     (acc_sum_c),
    .shift_i   (shift_q),
    .relu_en_i (relu_en_q),
    .data_c_o  (quant_c)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    psum_cnt_d = psum_cnt_q;
    out_cnt_d  = out_cnt_q;
    acc_len_d  = acc_len_q;
    num_out_d  = num_out_q;
    bias_d     = bias_q;
    shift_d    = shift_q;
    relu_en_d  = relu_en_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          acc_len_d  = (i_acc_len == '0) ? CNT_WIDTH'(1) : i_acc_len;
          num_out_d  = (i_num_out == '0) ? CNT_WIDTH'(1) : i_num_out;
          bias_d     = i_bias;
          shift_d    = i_shift;
          relu_en_d  = i_relu_en;
          acc_d      = i_bias;
          psum_cnt_d = '0;
          out_cnt_d  = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (psum_hs_c) begin
          acc_d      = acc_sum_c;
          psum_cnt_d = psum_cnt_q + CNT_WIDTH'(1);
          if (psum_cnt_q == acc_len_q - CNT_WIDTH'(1)) begin
            out_data_d = quant_c;
            state_d    = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_hs_c) begin
          out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
          if (out_cnt_q == num_out_q - CNT_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            acc_d      = bias_q;
            psum_cnt_d = '0;
            state_d    = ST_ACCUM;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    psum_ready_d = (state_d == ST_ACCUM);
    out_valid_d  = (state_d == ST_EMIT);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      psum_cnt_q   <= '0;
      out_cnt_q    <= '0;
      acc_len_q    <= '0;
      num_out_q    <= '0;
      bias_q       <= '0;
      shift_q      <= '0;
      relu_en_q    <= 1'b0;
      out_data_q   <= '0;
      psum_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      psum_cnt_q   <= psum_cnt_d;
      out_cnt_q    <= out_cnt_d;
      acc_len_q    <= acc_len_d;
      num_out_q    <= num_out_d;
      bias_q       <= bias_d;
      shift_q      <= shift_d;
      relu_en_q    <= relu_en_d;
      out_data_q   <= out_data_d;
      psum_ready_q <= psum_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_psum_ready = psum_ready_q;
  assign bus.o_out_valid  = out_valid_q;
  assign bus.o_out_data   = out_data_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expected activations.
module tb_psum_accumulator;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 19;
  localparam int unsigned AW  = 32;
  localparam int unsigned NW  = 8;
  localparam int unsigned SW  = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NW-1:0] acc_len;
  logic [NW-1:0] num_out;
  logic [AW-1:0] bias;
  logic [SW-1:0] shift;
  logic          relu_en;
  logic          busy;
  logic          done;

  int n_vec;
  int n_err;

  psum_accumulator_if #(.DATA_WIDTH(DW), .COLUMN_OUT_WIDTH(CW)) bus ();

  psum_accumulator #(
    .DATA_WIDTH       (DW),
    .COLUMN_OUT_WIDTH (CW),
    .ACC_WIDTH        (AW),
    .CNT_WIDTH        (NW),
    .SHIFT_WIDTH      (SW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_acc_len (acc_len),
    .i_num_out (num_out),
    .i_bias    (bias),
    .i_shift   (shift),
    .i_relu_en (relu_en),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable when this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int num, input int b,
                           input int sh, input bit relu);
    start   = 1'b1;
    acc_len = NW'(len);
    num_out = NW'(num);
    bias    = AW'(b);
    shift   = SW'(sh);
    relu_en = relu;
    tick();
    start   = 1'b0;
    acc_len = '0;
    num_out = '0;
    bias    = '0;
    shift   = '0;
    relu_en = 1'b0;
  endtask

  task automatic send_psum(input int val);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.i_psum_valid  = 1'b1;
    bus.i_psum_column = CW'(val);
    for (int i = 0; i < 20; i++) begin
      rdy = bus.o_psum_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_psum_valid = 1'b0;
    if (!ok) check("psum_timeout", 0, 1);
  endtask

  task automatic recv_out(input string tag, input int exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check("out_timeout", 0, 1);
    end else begin
      check(tag, int'($signed(bus.o_out_data)), exp);
      bus.i_out_ready = 1'b1;
      tick();
      bus.i_out_ready = 1'b0;
    end
  endtask

  // Single-output job: len psums, then check latency, value and done pulse.
  task automatic one_shot(input string tag, input int b, input int sh,
                          input bit relu, input int p0, input int p1, input int exp);
    start_job((p1 == 0) ? 1 : 2, 1, b, sh, relu);
    send_psum(p0);
    if (p1 != 0) send_psum(p1);
    check({tag, "_valid_lat"}, int'(bus.o_out_valid), 1);
    recv_out(tag, exp);
    check({tag, "_done"}, int'(done), 1);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst     = 1'b1;
    start   = 1'b0;
    acc_len = '0;
    num_out = '0;
    bias    = '0;
    shift   = '0;
    relu_en = 1'b0;
    bus.i_psum_valid  = 1'b0;
    bus.i_psum_column = '0;
    bus.i_out_ready   = 1'b0;
    repeat (3) tick();

    check("rst_out_valid",  int'(bus.o_out_valid),  0);
    check("rst_psum_ready", int'(bus.o_psum_ready), 0);
    check("rst_out_data",   int'(bus.o_out_data),   0);
    check("rst_busy",       int'(busy),             0);
    check("rst_done",       int'(done),             0);
    rst = 1'b0;
    tick();

    // Basic accumulation onto bias: 10+5-2+7.
    start_job(3, 1, 10, 0, 1'b0);
    check("t1_busy",  int'(busy), 1);
    check("t1_ready", int'(bus.o_psum_ready), 1);
    send_psum(5);
    send_psum(-2);
    check("t1_no_early_valid", int'(bus.o_out_valid), 0);
    send_psum(7);
    check("t1_valid_lat", int'(bus.o_out_valid), 1);
    recv_out("t1_data", 20);
    check("t1_done", int'(done), 1);
    check("t1_idle", int'(busy), 0);
    tick();
    check("t1_done_pulse", int'(done), 0);

    // Rounding shift and ReLU.
    one_shot("t2_pos",   0, 2, 1'b0,  6, 0,  2);
    one_shot("t2_neg",   0, 2, 1'b0, -7, 0, -2);
    one_shot("t2_relu",  0, 2, 1'b1, -7, 0,  0);

    // Saturation at both ends.
    one_shot("t3_satp",  0, 0, 1'b0,  100,  100,  127);
    one_shot("t3_satn",  0, 0, 1'b0, -100, -100, -128);

    // Backpressure in EMIT with a psum offered.
    start_job(1, 2, 0, 0, 1'b0);
    send_psum(50);
    bus.i_psum_valid  = 1'b1;
    bus.i_psum_column = CW'(99);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data",  int'($signed(bus.o_out_data)), 50);
      check("t4_hold_ready", int'(bus.o_psum_ready), 0);
      check("t4_hold_valid", int'(bus.o_out_valid), 1);
    end
    bus.i_psum_valid = 1'b0;
    recv_out("t4_data0", 50);
    check("t4_no_done", int'(done), 0);
    send_psum(3);
    recv_out("t4_data1", 3);
    check("t4_done", int'(done), 1);
    tick();

    // Multi-output job with bias reseed and an ignored mid-job start.
    start_job(2, 3, 5, 0, 1'b0);
    send_psum(1);
    send_psum(2);
    recv_out("t5_out0", 8);
    check("t5_no_done0", int'(done), 0);
    send_psum(10);
    start   = 1'b1;
    acc_len = NW'(1);
    num_out = NW'(1);
    bias    = AW'(100);
    tick();
    start   = 1'b0;
    acc_len = '0;
    num_out = '0;
    bias    = '0;
    check("t5_mid_start_busy", int'(busy), 1);
    send_psum(-20);
    recv_out("t5_out1", -5);
    check("t5_no_done1", int'(done), 0);
    send_psum(3);
    send_psum(3);
    recv_out("t5_out2", 11);
    check("t5_done", int'(done), 1);
    tick();
    check("t5_done_once", int'(done), 0);

    // Reset mid-ACCUM, then a fresh job with len=0.
    start_job(2, 1, 0, 0, 1'b0);
    send_psum(40);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", int'(bus.o_out_valid),  0);
    check("t6_rst_ready", int'(bus.o_psum_ready), 0);
    check("t6_rst_busy",  int'(busy),             0);
    check("t6_rst_done",  int'(done),             0);
    check("t6_rst_data",  int'(bus.o_out_data),   0);
    rst = 1'b0;
    tick();
    start_job(0, 0, 3, 0, 1'b0);
    send_psum(4);
    check("t6_len0_valid", int'(bus.o_out_valid), 1);
    recv_out("t6_data", 7);
    check("t6_done", int'(done), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
